// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: settles the oscillator, counts synchronized
// rising edges of ro_in over a selectable gate window, and holds a 12-bit result.
module ro_freq_counter #(
  parameter int SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] gate_sel,
  input  logic       ro_in,
  input  logic       byte_sel,
  output logic       ro_en,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic [7:0] data_out
);
  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;
  state_t state, nxt;

  logic            s1, s2, s3, rise;
  logic [SCW-1:0]  settle_cnt;
  logic [1:0]      win;
  logic [13:0]     gate_cnt, gate_max;
  logic [11:0]     edge_cnt, result;
  logic            ovf_int, settle_last, gate_last, sat;

  assign rise        = s2 & ~s3;
  assign sat         = &edge_cnt;
  assign settle_last = (settle_cnt == SCW'(SETTLE_CYC - 1));
  assign gate_last   = (gate_cnt == gate_max);

  always_comb begin
    case (win)
      2'd0:    gate_max = 14'd255;
      2'd1:    gate_max = 14'd1023;
      2'd2:    gate_max = 14'd4095;
      default: gate_max = 14'd16383;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start)       nxt = SETTLE;
      SETTLE:     if (settle_last) nxt = GATE;
      GATE:       if (gate_last)   nxt = DONE;
      default:                     nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Status outputs are flops fed from next-state so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ro_en <= (nxt == SETTLE) || (nxt == GATE);
      busy  <= (nxt == SETTLE) || (nxt == GATE);
      done  <= (nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      win        <= 2'd0;
      gate_cnt   <= 14'd0;
      edge_cnt   <= 12'd0;
      ovf_int    <= 1'b0;
      result     <= 12'd0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          settle_cnt <= '0;
          win        <= gate_sel;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_last) begin
            gate_cnt <= 14'd0;
            edge_cnt <= 12'd0;
            ovf_int  <= 1'b0;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + 14'd1;
          if (rise) begin
            if (sat) ovf_int  <= 1'b1;
            else     edge_cnt <= edge_cnt + 12'd1;
          end
          // Final-cycle edge must land in the result, so fold it in here.
          if (gate_last) begin
            result <= (rise && !sat) ? edge_cnt + 12'd1 : edge_cnt;
            ovf    <= ovf_int | (rise & sat);
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out = byte_sel ? {ovf, 3'b000, result[11:8]} : result[7:0];
endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: drives ro_in patterns and checks results against a
// model that counts 0->1 transitions of the sampled ro_in waveform in the window.
module tb_ro_freq_counter;
  localparam int SC = 16;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ro_in = 1'b0, byte_sel = 1'b0;
  logic [1:0] gate_sel = 2'd0;
  logic       ro_en, busy, done, ovf;
  logic [7:0] data_out;

  int checks = 0, errors = 0;

  ro_freq_counter #(.SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel), .ro_in(ro_in),
    .byte_sel(byte_sel), .ro_en(ro_en), .busy(busy), .done(done), .ovf(ovf),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Sampled ro_in history, one entry per rising edge.
  logic rohist [0:131071];
  int   cyc = 0;
  always @(posedge clk) begin
    if (cyc < 131072) rohist[cyc] = ro_in;
    cyc = cyc + 1;
  end

  // ro_in generator: 0 = hold, 1 = toggle every 'half' cycles, 2 = random level.
  int mode = 0, half = 4, ph = 0;
  always @(negedge clk) begin
    case (mode)
      1: begin
        ph = ph + 1;
        if (ph >= half) begin ph = 0; ro_in = ~ro_in; end
      end
      2: ro_in = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  function automatic int win_len(input logic [1:0] g);
    return 256 << (2 * int'(g));
  endfunction

  // Two-flop sync plus edge flop: the edge seen in window cycle k came from
  // samples k-3 (low) and k-2 (high) relative to the start edge.
  function automatic int model_count(input int s0, input int n);
    int c = 0;
    for (int k = SC + 1; k <= SC + n; k++)
      if (rohist[s0 + k - 3] == 1'b0 && rohist[s0 + k - 2] == 1'b1) c++;
    return c;
  endfunction

  logic [7:0] b0, b1;

  task automatic read_bytes();
    byte_sel = 1'b0; #1; b0 = data_out;
    byte_sel = 1'b1; #1; b1 = data_out;
    byte_sel = 1'b0;
  endtask

  task automatic pulse_start(output int s0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    s0 = cyc - 1;
  endtask

  // One measurement; checks timing, ro_en, and both readout bytes vs the model.
  task automatic run(input string nm, input logic [1:0] gs, input bit disturb,
                     output logic [11:0] res, output logic ov);
    int s0, n, t, bc, enerr, mc, exp_res;
    bit exp_ovf;
    gate_sel = gs;
    n = win_len(gs);
    pulse_start(s0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_ack: done=%b busy=%b required done=0 busy=1", nm, done, busy);
    end
    t = 0; bc = 0; enerr = 0;
    while (done !== 1'b1 && t < 20000) begin
      if (busy === 1'b1) bc++;
      if (ro_en !== busy) enerr++;
      if (disturb) begin
        start = (t == SC + 100);
        if (t == SC + 101) gate_sel = ~gs;
      end
      @(negedge clk); t++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", nm, done, t);
    end
    checks++;
    if (bc != SC + n) begin
      errors++;
      $display("FAIL %s busy_len: got %0d required %0d", nm, bc, SC + n);
    end
    checks++;
    if (enerr != 0 || ro_en !== 1'b0) begin
      errors++;
      $display("FAIL %s ro_en: %0d cycles differ from busy, final ro_en=%b required 0", nm, enerr, ro_en);
    end
    mc = model_count(s0, n);
    exp_ovf = (mc > 4095);
    exp_res = exp_ovf ? 4095 : mc;
    read_bytes();
    res = {b1[3:0], b0};
    ov  = b1[7];
    checks++;
    if (b0 !== exp_res[7:0]) begin
      errors++;
      $display("FAIL %s byte0: got %h required %h", nm, b0, exp_res[7:0]);
    end
    checks++;
    if (b1 !== {exp_ovf, 3'b000, exp_res[11:8]} || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s byte1: got %h ovf=%b required %h ovf=%b", nm, b1, ovf,
               {exp_ovf, 3'b000, exp_res[11:8]}, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 0; ro_in = 1'b0;
    repeat (3) @(negedge clk);
    read_bytes();
    checks++;
    if ({ro_en, busy, done, ovf} !== 4'b0 || b0 !== 8'h00 || b1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: ro_en=%b busy=%b done=%b ovf=%b b0=%h b1=%h required all 0",
               ro_en, busy, done, ovf, b0, b1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_period8();
    logic [11:0] r; logic o;
    mode = 1; half = 4;
    run("period8", 2'd0, 1'b0, r, o);
    checks++;
    if (r !== 12'h020 || o !== 1'b0) begin
      errors++;
      $display("FAIL period8_const: got %h ovf=%b required 020 ovf=0", r, o);
    end
  endtask

  task automatic test_hold0();
    logic [11:0] r; logic o;
    mode = 0; ro_in = 1'b0;
    run("hold0", 2'd3, 1'b0, r, o);
    checks++;
    if (r !== 12'h000 || o !== 1'b0) begin
      errors++;
      $display("FAIL hold0_const: got %h ovf=%b required 000 ovf=0", r, o);
    end
  endtask

  task automatic test_saturate();
    logic [11:0] r; logic o;
    mode = 1; half = 1;
    run("saturate", 2'd3, 1'b0, r, o);
    checks++;
    if (r !== 12'hFFF || o !== 1'b1 || b1 !== 8'h8F) begin
      errors++;
      $display("FAIL saturate_const: got %h ovf=%b b1=%h required FFF ovf=1 b1=8F", r, o, b1);
    end
  endtask

  task automatic test_restart_ignored();
    logic [11:0] r; logic o;
    mode = 2;
    run("restart_ignored", 2'd1, 1'b1, r, o);
  endtask

  task automatic test_abort();
    int s0;
    logic [11:0] r; logic o;
    mode = 1; half = 3;
    gate_sel = 2'd1;
    pulse_start(s0);
    repeat (SC + 50) @(negedge clk);
    rst_n = 1'b0; #1;
    read_bytes();
    checks++;
    if ({ro_en, busy, done} !== 3'b000 || b0 !== 8'h00 || b1 !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset: ro_en=%b busy=%b done=%b b0=%h b1=%h required all 0",
               ro_en, busy, done, b0, b1);
    end
    @(negedge clk); rst_n = 1'b1;
    run("abort_rerun", 2'd1, 1'b0, r, o);
  endtask

  task automatic test_back_to_back();
    logic [11:0] r; logic o;
    mode = 1; half = 4;
    run("b2b_p8", 2'd1, 1'b0, r, o);
    checks++;
    if (r !== 12'h080) begin
      errors++;
      $display("FAIL b2b_p8_const: got %h required 080", r);
    end
    half = 8;
    run("b2b_p16", 2'd1, 1'b0, r, o);
    checks++;
    if (r !== 12'h040) begin
      errors++;
      $display("FAIL b2b_p16_const: got %h required 040", r);
    end
  endtask

  task automatic test_random();
    logic [11:0] r; logic o;
    for (int i = 0; i < 4; i++) begin
      mode = int'($urandom_range(1, 2));
      half = int'($urandom_range(1, 7));
      run("random", 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), r, o);
    end
  endtask

  initial begin
    test_reset();
    test_period8();
    test_hold0();
    test_saturate();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
